// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
//   fwd_sel_t  : execute-stage operand mux select
//   hz_state_t : sequencing FSM state
//   addr_hit() : register address compare with optional r0 exclusion
package pipeline_ctrl_pkg;

  localparam int REG_ADDR_W = 3;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b10
  } hz_state_t;

  // True when a and b name the same register; r0 never matches when zero_en.
  function automatic logic addr_hit(input logic [REG_ADDR_W-1:0] a,
                                    input logic [REG_ADDR_W-1:0] b,
                                    input logic                  zero_en);
    return (a == b) && !(zero_en && (a == '0));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// forward_unit: forwarding select for one execute-stage operand.
//   ra          : operand source address in E
//   wa3m, wa3w  : destination addresses in M and W
//   regwrite_m/w: M / W instruction writes the register file
//   sel         : FWD_MEM beats FWD_WB (M holds the younger result)
module forward_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter bit ZERO_REG_EN = 1'b0
) (
  input  logic [REG_ADDR_W-1:0] ra,
  input  logic [REG_ADDR_W-1:0] wa3m,
  input  logic [REG_ADDR_W-1:0] wa3w,
  input  logic                  regwrite_m,
  input  logic                  regwrite_w,
  output fwd_sel_t              sel
);

  always_comb begin
    sel = FWD_RF;
    if (regwrite_m && addr_hit(ra, wa3m, ZERO_REG_EN))      sel = FWD_MEM;
    else if (regwrite_w && addr_hit(ra, wa3w, ZERO_REG_EN)) sel = FWD_WB;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forward control for the 5-stage pipe.
//   clk, reset            : core clock, async active-low reset
//   RA1D/RA2D, RA1E/RA2E  : source addresses in D and E
//   WA3E/WA3M/WA3W        : destination addresses in E, M, W
//   MemtoRegE             : E holds a load
//   RegWriteM/RegWriteW   : M / W writes the register file
//   BranchTakenE          : taken branch resolved in E
//   MemAccessM, MemReady  : data-memory access in M and its completion
//   ForwardAE/BE          : operand selects (00 RF, 01 W, 10 M)
//   StallF/D/E/M          : hold PC and D/E/M registers
//   FlushD/E/M            : clear F/D, D/E, E/M registers
//   Halt                  : sticky memory-timeout halt
//   StallCnt/FlushCnt     : saturating perf counters
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16,
  parameter int ZERO_REG_EN = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] RA1D,
  input  logic [REG_ADDR_W-1:0] RA2D,
  input  logic [REG_ADDR_W-1:0] RA1E,
  input  logic [REG_ADDR_W-1:0] RA2E,
  input  logic [REG_ADDR_W-1:0] WA3E,
  input  logic [REG_ADDR_W-1:0] WA3M,
  input  logic [REG_ADDR_W-1:0] WA3W,
  input  logic                  MemtoRegE,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  BranchTakenE,
  input  logic                  MemAccessM,
  input  logic                  MemReady,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushM,
  output logic                  Halt,
  output logic [CNT_W-1:0]      StallCnt,
  output logic [CNT_W-1:0]      FlushCnt
);

  // Wide enough to hold MEM_TIMEOUT itself.
  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 2);
  localparam bit ZR     = (ZERO_REG_EN != 0);

  hz_state_t         state, state_d;
  logic [WCNT_W-1:0] wait_cnt, wait_d, wait_nxt;
  logic              timeout, load_use, mem_miss;
  logic              stall_all, stall_fd, flush_d, flush_e;
  fwd_sel_t          fwd_a, fwd_b;

  forward_unit #(.ZERO_REG_EN(ZR)) u_fwd_a (
    .ra(RA1E), .wa3m(WA3M), .wa3w(WA3W),
    .regwrite_m(RegWriteM), .regwrite_w(RegWriteW), .sel(fwd_a)
  );

  forward_unit #(.ZERO_REG_EN(ZR)) u_fwd_b (
    .ra(RA2E), .wa3m(WA3M), .wa3w(WA3W),
    .regwrite_m(RegWriteM), .regwrite_w(RegWriteW), .sel(fwd_b)
  );

  assign load_use = MemtoRegE && (addr_hit(WA3E, RA1D, ZR) || addr_hit(WA3E, RA2D, ZR));
  assign mem_miss = MemAccessM && !MemReady;
  assign wait_nxt = wait_cnt + WCNT_W'(1);
  // wait_nxt counts the current wait cycle; reaching the limit ends the wait.
  assign timeout  = (int'(wait_nxt) >= MEM_TIMEOUT);

  always_comb begin
    state_d   = state;
    wait_d    = wait_cnt;
    stall_all = 1'b0;
    stall_fd  = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    unique case (state)
      RUN: begin
        if (mem_miss) begin
          stall_all = 1'b1;
          state_d   = MEM_WAIT;
          wait_d    = '0;
        end else begin
          // Branch wins: the load-use bubble would be squashed anyway.
          flush_d  = BranchTakenE;
          flush_e  = BranchTakenE || load_use;
          stall_fd = load_use && !BranchTakenE;
        end
      end
      MEM_WAIT: begin
        // E is frozen, so a pending branch re-presents itself after the wait.
        stall_all = 1'b1;
        if (MemReady) begin
          state_d = RUN;
          wait_d  = '0;
        end else begin
          wait_d = wait_nxt;
          if (timeout) state_d = HALT;
        end
      end
      HALT:    stall_all = 1'b1;
      default: state_d = RUN;
    endcase
  end

  // Reset overrides combinationally: flush everything, stall nothing.
  assign StallF    = reset && (stall_all || stall_fd);
  assign StallD    = reset && (stall_all || stall_fd);
  assign StallE    = reset && stall_all;
  assign StallM    = reset && stall_all;
  assign FlushD    = !reset || flush_d;
  assign FlushE    = !reset || flush_e;
  assign FlushM    = !reset;
  assign ForwardAE = reset ? fwd_a : FWD_RF;
  assign ForwardBE = reset ? fwd_b : FWD_RF;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      wait_cnt <= '0;
      StallCnt <= '0;
      FlushCnt <= '0;
      Halt     <= 1'b0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_d;
      if (StallF && !(&StallCnt))             StallCnt <= StallCnt + CNT_W'(1);
      if ((FlushD || FlushE) && !(&FlushCnt)) FlushCnt <= FlushCnt + CNT_W'(1);
      // Registered from the state, so Halt trails entry into HALT by a cycle.
      if (state == HALT)                      Halt     <= 1'b1;
    end
  end

endmodule
